// File: rtl/mips_fetch_decode.sv
// MIPS-lite front end: PC register, instruction ROM `im`, next-PC select and main decoder.
// Optional macro ADDI_OVF_EN enables decoding of addi as an overflow-checked add.
module mips_fetch_decode #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic [31:0] jr_in,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic [31:0] jal_save,
    output logic [1:0]  regDst,
    output logic        ALUSrc,
    output logic [1:0]  writeData,
    output logic        regWrite,
    output logic        memWrite,
    output logic [2:0]  nPCsel,
    output logic [1:0]  extsel,
    output logic [1:0]  ALUsel,
    output logic        overflow
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_JMP  = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;

    // Instruction ROM; contents are loaded from outside by hierarchical reference, so it has no reset.
    logic [31:0] im [0:IMEM_WORDS-1];

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [7:0]  w_word_idx;
    logic [5:0]  w_op;
    logic [5:0]  w_fn;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_pc <= PC_RESET;
        else       r_pc <= npc;
    end

    // Only pc[9:2] addresses the ROM, so fetch wraps every 1 KiB.
    assign w_word_idx  = r_pc[9:2];
    assign w_op        = instr[31:26];
    assign w_fn        = instr[5:0];

    assign pc          = r_pc;
    assign instr       = im[w_word_idx];
    assign w_pc_plus4  = r_pc + 32'd4;
    assign jal_save    = w_pc_plus4;
    assign w_br_target = w_pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        npc = w_pc_plus4;
        case (nPCsel)
            NPC_BEQ: npc = zero ? w_br_target : w_pc_plus4;
            NPC_JMP: npc = w_j_target;
            NPC_JR:  npc = jr_in;
            default: npc = w_pc_plus4;
        endcase
    end

    // NOTE: every decoder output gets a default first so no path through the case infers a latch.
    always_comb begin
        regDst    = 2'b00;
        ALUSrc    = 1'b0;
        writeData = 2'b00;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        nPCsel    = NPC_SEQ;
        extsel    = 2'b00;
        ALUsel    = 2'b00;
        overflow  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADDU: begin
                        regDst   = 2'b01;
                        regWrite = 1'b1;
                    end
                    FN_SUBU: begin
                        regDst   = 2'b01;
                        regWrite = 1'b1;
                        ALUsel   = 2'b01;
                    end
                    FN_JR: begin
                        nPCsel   = NPC_JR;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
                ALUsel   = 2'b10;
            end
            OP_LW: begin
                ALUSrc    = 1'b1;
                writeData = 2'b01;
                regWrite  = 1'b1;
                extsel    = 2'b01;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                memWrite = 1'b1;
                extsel   = 2'b01;
            end
            OP_BEQ: begin
                nPCsel = NPC_BEQ;
                extsel = 2'b01;
                ALUsel = 2'b01;
            end
            OP_LUI: begin
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
                extsel   = 2'b10;
                ALUsel   = 2'b10;
            end
            OP_J: begin
                nPCsel = NPC_JMP;
            end
            OP_JAL: begin
                regDst    = 2'b10;
                writeData = 2'b10;
                regWrite  = 1'b1;
                nPCsel    = NPC_JMP;
            end
`ifdef ADDI_OVF_EN
            OP_ADDI: begin
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
                extsel   = 2'b01;
                overflow = 1'b1;
            end
`else
            OP_ADDI: ;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Directed bench for mips_fetch_decode: loads a small program into `im` and walks it
// through sequential, branch, jump, jr, wrap-around and mid-run reset cases.
module tb_mips_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero;
    logic [31:0] jr_in;
    logic [31:0] pc, instr, npc, jal_save;
    logic [1:0]  regDst, writeData, extsel, ALUsel;
    logic        ALUSrc, regWrite, memWrite, overflow;
    logic [2:0]  nPCsel;

    int n_vec  = 0;
    int n_miss = 0;

    mips_fetch_decode dut (
        .clk(clk), .reset(reset), .zero(zero), .jr_in(jr_in),
        .pc(pc), .instr(instr), .npc(npc), .jal_save(jal_save),
        .regDst(regDst), .ALUSrc(ALUSrc), .writeData(writeData),
        .regWrite(regWrite), .memWrite(memWrite), .nPCsel(nPCsel),
        .extsel(extsel), .ALUsel(ALUsel), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Strobes packed as {regDst,ALUSrc,writeData,regWrite,memWrite,nPCsel,extsel,ALUsel,overflow}.
    logic [14:0] w_ctl;
    assign w_ctl = {regDst, ALUSrc, writeData, regWrite, memWrite, nPCsel, extsel, ALUsel, overflow};

    localparam logic [14:0] C_ADDU = {2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] C_SUBU = {2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] C_JR   = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] C_ORI  = {2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] C_LW   = {2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] C_SW   = {2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] C_BEQ  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 2'b01, 2'b01, 1'b0};
    localparam logic [14:0] C_LUI  = {2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 2'b10, 2'b10, 1'b0};
    localparam logic [14:0] C_J    = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] C_JAL  = {2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] C_NOP  = 15'd0;
`ifdef ADDI_OVF_EN
    localparam logic [14:0] C_ADDI = {2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 2'b01, 2'b00, 1'b1};
`else
    localparam logic [14:0] C_ADDI = C_NOP;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        jr_in = 32'd0;
        for (int i = 0; i < 256; i++) dut.im[i] = 32'h0000_0000;
        dut.im[0]  = 32'h0022_1821; // 0x3000 addu
        dut.im[1]  = 32'h3401_0005; // 0x3004 ori
        dut.im[2]  = 32'h1000_0003; // 0x3008 beq +3
        dut.im[3]  = 32'h8C22_0004; // 0x300C lw
        dut.im[4]  = 32'h0C00_0C00; // 0x3010 jal 0x3000
        dut.im[6]  = 32'h03E0_0008; // 0x3018 jr $31
        dut.im[8]  = 32'hAC22_0008; // 0x3020 sw
        dut.im[9]  = 32'hFC00_0000; // 0x3024 unknown op 0x3F
        dut.im[10] = 32'h2001_0005; // 0x3028 addi
        dut.im[11] = 32'h3C01_1234; // 0x302C lui
        dut.im[12] = 32'h0022_1823; // 0x3030 subu
        dut.im[13] = 32'h0800_0C00; // 0x3034 j 0x3000

        step();
        check("rst_pc",    pc,    32'h3000);
        check("rst_instr", instr, 32'h0022_1821);
        check("addu_ctl",  {17'd0, w_ctl}, {17'd0, C_ADDU});
        check("addu_npc",  npc,      32'h3004);
        check("addu_link", jal_save, 32'h3004);

        reset = 1'b0;
        step();
        check("seq_pc",  pc, 32'h3004);
        check("ori_ctl", {17'd0, w_ctl}, {17'd0, C_ORI});

        step();
        check("beq_pc",  pc, 32'h3008);
        check("beq_ctl", {17'd0, w_ctl}, {17'd0, C_BEQ});
        zero = 1'b1; #1;
        check("beq_taken",    npc, 32'h3018);
        zero = 1'b0; #1;
        check("beq_nottaken", npc, 32'h300C);
        dut.im[2] = 32'h1000_FFFF;
        zero = 1'b1; #1;
        check("beq_back", npc, 32'h3008);
        dut.im[2] = 32'h1000_0003;
        zero = 1'b0; #1;

        step();
        check("lw_pc",  pc, 32'h300C);
        check("lw_ctl", {17'd0, w_ctl}, {17'd0, C_LW});

        step();
        check("jal_pc",   pc, 32'h3010);
        check("jal_ctl",  {17'd0, w_ctl}, {17'd0, C_JAL});
        check("jal_npc",  npc,      32'h3000);
        check("jal_link", jal_save, 32'h3014);

        step();
        check("jal_dest", pc, 32'h3000);
        step();
        step();
        check("beq2_pc", pc, 32'h3008);
        zero = 1'b1;
        step();
        zero = 1'b0;
        check("beq_dest", pc, 32'h3018);
        jr_in = 32'h3020; #1;
        check("jr_ctl", {17'd0, w_ctl}, {17'd0, C_JR});
        check("jr_npc", npc, 32'h3020);
        // Target above 1 KiB: fetch must wrap to word 8.
        jr_in = 32'h3420; #1;
        check("jr_npc2", npc, 32'h3420);

        step();
        check("jr_dest",   pc,    32'h3420);
        check("wrap_inst", instr, 32'hAC22_0008);
        check("sw_ctl",    {17'd0, w_ctl}, {17'd0, C_SW});

        step();
        check("unk_ctl", {17'd0, w_ctl}, {17'd0, C_NOP});
        check("unk_npc", npc, 32'h3428);

        step();
        check("addi_ctl", {17'd0, w_ctl}, {17'd0, C_ADDI});
        check("addi_npc", npc, 32'h342C);

        step();
        check("lui_ctl", {17'd0, w_ctl}, {17'd0, C_LUI});
        step();
        check("subu_ctl", {17'd0, w_ctl}, {17'd0, C_SUBU});
        step();
        check("j_pc",  pc, 32'h3434);
        check("j_ctl", {17'd0, w_ctl}, {17'd0, C_J});
        check("j_npc", npc, 32'h3000);

        // Reset mid-run overrides the jump on this edge.
        dut.im[13] = 32'h0800_0C10;
        #1;
        check("j_npc2", npc, 32'h3040);
        reset = 1'b1;
        step();
        check("midrst_pc",    pc,    32'h3000);
        check("midrst_instr", instr, 32'h0022_1821);
        reset = 1'b0;
        step();
        check("post_rst_pc", pc, 32'h3004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
